// File: rtl/alu_pkg.sv
// Shared widths, op-tag encodings and result-stage state encoding
// for the bitwise logic unit datapath.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_zero_detect.sv
// WIDTH-input NOR reduction; flags an all-zero result word.
module alu_zero_detect #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] word,
   output logic             zero
);

   assign zero = ~|word;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage: 2-entry skid buffer with op tag, captured zero flag
// and a saturating count of accepted results.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OP_W  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [OP_W-1:0]  out_op,
   output logic             out_zero,
   output logic [CNT_W-1:0] acc_count
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] main_res, skid_res;
   logic [OP_W-1:0]  main_op, skid_op;
   logic             main_zero, skid_zero;
   logic             in_zero;
   logic             in_ready_q;
   logic             accept, pop;
   logic             load_main_in, load_main_skid, load_skid;

   alu_zero_detect #(.WIDTH(WIDTH)) u_zero (
      .word (in_result),
      .zero (in_zero)
   );

   assign accept     = in_valid & in_ready_q;
   assign out_valid  = (state != EMPTY);
   assign pop        = out_valid & out_ready;
   assign in_ready   = in_ready_q;
   assign out_result = main_res;
   assign out_op     = main_op;
   assign out_zero   = main_zero;

   always_comb begin
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_nx     = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nx  = FULL;
            end else if (pop) begin
               state_nx = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               load_main_skid = 1'b1;
               state_nx       = ONE;
            end
         end
         default: state_nx = EMPTY;
      endcase
      // Flush discards any capture this cycle so out_* keep their last value.
      if (flush) begin
         state_nx       = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nx;
         in_ready_q <= (state_nx != FULL);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_res  <= '0;
         main_op   <= '0;
         main_zero <= 1'b0;
         skid_res  <= '0;
         skid_op   <= '0;
         skid_zero <= 1'b0;
      end else begin
         if (load_main_in) begin
            main_res  <= in_result;
            main_op   <= in_op;
            main_zero <= in_zero;
         end else if (load_main_skid) begin
            main_res  <= skid_res;
            main_op   <= skid_op;
            main_zero <= skid_zero;
         end
         if (load_skid) begin
            skid_res  <= in_result;
            skid_op   <= in_op;
            skid_zero <= in_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_count <= '0;
      end else if (accept && (acc_count != '1)) begin
         acc_count <= acc_count + 1'b1;
      end
   end

endmodule
